// File: rtl/lifo_pkg.sv
// Shared constants and types for the LIFO data stage and its storage.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package lifo_pkg;

   localparam int DWIDTH_DEF = 8;
   localparam int AWIDTH_DEF = 4;

   // Drop counter width and the value it sticks at once saturated.
   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

   // Per-cycle error events; the two are mutually exclusive because an
   // overflow needs wrreq and an underflow needs ~wrreq.
   typedef struct packed {
      logic ovf;
      logic udf;
   } err_ev_t;

   // Saturating increment for the drop counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
// Latency: read data appears 1 cycle after re; write visible to reads on the next edge.
// Backpressure: none; the caller guarantees no same-cycle write/read of one word.
module lifo_ram
   import lifo_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];

   // Write port: storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port: holds its value when no read is accepted.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lifo_data_stage.sv
// LIFO data path: qualifies pops, drives storage, tracks overflow/underflow and drops.
// Latency: 1 cycle from accepted pop to q_o/q_valid_o.
// Backpressure: none; full/empty come from the pointer stage and excess requests are dropped and counted.
module lifo_data_stage
   import lifo_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   input  logic              wren_i,
   input  logic [AWIDTH-1:0] wrpntr_i,
   input  logic [AWIDTH-1:0] rdpntr_i,
   input  logic              empty_i,
   input  logic              full_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              clr_err_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              q_valid_o,
   output logic              ovf_o,
   output logic              udf_o,
   output logic [CNT_W-1:0]  drop_cnt_o
);

   logic              rden;
   err_ev_t           ev;
   logic [DWIDTH-1:0] ram_q;
   logic              q_loaded;

   // Pop qualification (write wins, as in the pointer stage) and error events.
   always_comb begin
      rden   = rdreq_i & ~wrreq_i & ~empty_i;
      ev.ovf = wrreq_i & full_i;
      ev.udf = rdreq_i & ~wrreq_i & empty_i;
   end

   lifo_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clk   (clk_i),
      .we    (wren_i),
      .waddr (wrpntr_i),
      .wdata (data_i),
      .re    (rden),
      .raddr (rdpntr_i),
      .rdata (ram_q)
   );

   // Valid strobe plus a marker that the RAM read register holds popped data;
   // the RAM register has no reset, so q_o is forced to zero until the first pop.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         q_valid_o <= 1'b0;
         q_loaded  <= 1'b0;
      end else begin
         q_valid_o <= rden;
         q_loaded  <= q_loaded | rden;
      end
   end

   assign q_o = q_loaded ? ram_q : '0;

   // Sticky flags and saturating drop counter; a same-cycle event beats clear.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ovf_o      <= 1'b0;
         udf_o      <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         ovf_o <= ev.ovf | (ovf_o & ~clr_err_i);
         udf_o <= ev.udf | (udf_o & ~clr_err_i);
         if (clr_err_i)
            drop_cnt_o <= (ev.ovf | ev.udf) ? CNT_W'(1) : '0;
         else if (ev.ovf | ev.udf)
            drop_cnt_o <= sat_inc(drop_cnt_o);
      end
   end

endmodule

// File: tb/tb_lifo_data_stage.sv
// Directed bench for lifo_data_stage with a small pointer-stage model.
// Latency: checks outputs 2 time units after each rising edge.
// Backpressure: the bench derives full/empty from its own stack depth.
module tb_lifo_data_stage;

   logic       clk_i = 1'b0;
   logic       arst_i;
   logic       wrreq_i, rdreq_i, wren_i;
   logic [3:0] wrpntr_i, rdpntr_i;
   logic       empty_i, full_i;
   logic [7:0] data_i;
   logic       clr_err_i;
   logic [7:0] q_o;
   logic       q_valid_o, ovf_o, udf_o;
   logic [7:0] drop_cnt_o;

   int total = 0;
   int bad   = 0;
   int sp    = 0;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] d;
      logic       clr;
      logic [7:0] q;
      logic       qv;
      logic       ovf;
      logic       udf;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs [11];

   lifo_data_stage dut (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .wrreq_i    (wrreq_i),
      .rdreq_i    (rdreq_i),
      .wren_i     (wren_i),
      .wrpntr_i   (wrpntr_i),
      .rdpntr_i   (rdpntr_i),
      .empty_i    (empty_i),
      .full_i     (full_i),
      .data_i     (data_i),
      .clr_err_i  (clr_err_i),
      .q_o        (q_o),
      .q_valid_o  (q_valid_o),
      .ovf_o      (ovf_o),
      .udf_o      (udf_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [7:0] q, input logic qv,
                          input logic ovf, input logic udf, input logic [7:0] cnt);
      chk({name, ".q"},   32'(q_o),        32'(q));
      chk({name, ".qv"},  32'(q_valid_o),  32'(qv));
      chk({name, ".ovf"}, 32'(ovf_o),      32'(ovf));
      chk({name, ".udf"}, 32'(udf_o),      32'(udf));
      chk({name, ".cnt"}, 32'(drop_cnt_o), 32'(cnt));
   endtask

   // Drive request inputs with pointer-stage status from the bench stack depth.
   task automatic drive(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
      wrreq_i   = wr;
      rdreq_i   = rd;
      data_i    = d;
      clr_err_i = clr;
      full_i    = (sp == 16);
      empty_i   = (sp == 0);
      wren_i    = wr & ~full_i;
      wrpntr_i  = 4'(sp);
      rdpntr_i  = 4'(sp - 1);
   endtask

   // One cycle: drive, take the edge, update the stack depth, settle.
   task automatic step(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
      drive(wr, rd, d, clr);
      @(posedge clk_i);
      if (wr && sp < 16) sp++;
      else if (!wr && rd && sp > 0) sp--;
      #2;
   endtask

   initial begin
      //        wr    rd    data   clr   q      qv    ovf   udf   cnt
      vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 8'd1};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'd0};

      // Reset state
      arst_i = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      arst_i = 1'b0;

      // Push/pop ordering, underflow, write-priority suppression, clear
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].wr, vecs[i].rd, vecs[i].d, vecs[i].clr);
         chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].qv, vecs[i].ovf, vecs[i].udf, vecs[i].cnt);
      end

      // Fill to full, overflow push must not overwrite the top
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
      chk_all("fill", 8'h44, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'hAA, 1'b0);
      chk_all("ovf_push", 8'h44, 1'b0, 1'b1, 1'b0, 8'd1);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk_all("pop_after_ovf", 8'h0F, 1'b1, 1'b1, 1'b0, 8'd1);
      for (int i = 14; i >= 0; i--) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         chk($sformatf("drain%0d.q", i), 32'(q_o), 32'(i));
      end

      // Saturation of the drop counter
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk_all("clr2", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0);
         if (i == 253) chk("cnt_254", 32'(drop_cnt_o), 32'd254);
         if (i == 254) chk("cnt_255", 32'(drop_cnt_o), 32'd255);
      end
      chk_all("sat", 8'h00, 1'b0, 1'b0, 1'b1, 8'd255);

      // Clear with a simultaneous overflow: set beats clear
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      step(1'b1, 1'b0, 8'hBB, 1'b1);
      chk_all("clr_vs_ovf", 8'h00, 1'b0, 1'b1, 1'b0, 8'd1);

      // Reset mid-cycle with a pop pending
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk_all("pre_rst", 8'h8F, 1'b1, 1'b1, 1'b0, 8'd1);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      #1;
      arst_i = 1'b1;
      #1;
      chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      sp = 0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      arst_i = 1'b0;
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk_all("post_rst", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'h5A, 1'b0);
      chk_all("push_5a", 8'h00, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk_all("pop_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk_all("idle_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
